// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: configurable data bits, parity, stop bits, 3-bit baud select.
// Latency: tx_data falls 2 clocks after a write into an empty FIFO while idle; frames run back-to-back.
// Backpressure: full is asserted at FIFO_DEPTH words; further writes are dropped and flagged on overflow.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk_50mhz,
    input  logic                         rst,
    input  logic [2:0]                   baud,
    input  logic                         wr_en,
    input  logic [DATA_BITS-1:0]         wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         overflow,
    output logic                         busy,
    output logic                         tx_data,
    output logic                         tx_done
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int DIV_MAX = CLK_FREQ / 9600;
    localparam int CW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Bit period minus one, so the bit counter can compare against it directly.
    function automatic logic [CW-1:0] div_m1(input logic [2:0] b);
        case (b)
            3'd0:    div_m1 = CW'(CLK_FREQ / 9600 - 1);
            3'd1:    div_m1 = CW'(CLK_FREQ / 19200 - 1);
            3'd2:    div_m1 = CW'(CLK_FREQ / 38400 - 1);
            3'd3:    div_m1 = CW'(CLK_FREQ / 57600 - 1);
            default: div_m1 = CW'(CLK_FREQ / 115200 - 1);
        endcase
    endfunction

    state_t                 state, state_n;
    logic                   push, pop, bit_end, last_data, last_stop, frame_end;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            level_n;
    logic [CW-1:0]          cnt, div_q;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;

    assign push      = wr_en & ~full;
    assign bit_end   = (cnt == div_q);
    assign last_data = (bit_idx == 3'(DATA_BITS - 1));
    assign last_stop = (bit_idx == 3'(STOP_BITS - 1));
    assign busy      = (state != S_IDLE);

    // Next state and FIFO pop; a pop at the end of a frame chains straight into the next start bit.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START:  if (bit_end) state_n = S_DATA;
            S_DATA:   if (bit_end && last_data) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_n = S_STOP;
            S_STOP: begin
                if (bit_end && last_stop) begin
                    frame_end = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Occupancy after this edge, used to register full/empty/level.
    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (!push && pop)
            level_n = level - 1'b1;
    end

    // State register.
    always_ff @(posedge clk_50mhz) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_50mhz) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and status; overflow looks at the registered full so a same-cycle pop does not rescue the write.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level    <= level_n;
            full     <= (level_n == FULL_LVL);
            empty    <= (level_n == '0);
            overflow <= wr_en & full;
        end
    end

    // Serialiser datapath; tx_data is registered from the current state, one clock behind the FSM.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            cnt     <= '0;
            div_q   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_data <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= frame_end;
            case (state)
                S_START:  tx_data <= 1'b0;
                S_DATA:   tx_data <= shreg[0];
                S_PARITY: tx_data <= par_bit;
                default:  tx_data <= 1'b1;
            endcase
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
                div_q   <= div_m1(baud);
                cnt     <= '0;
                bit_idx <= '0;
            end else if (state != S_IDLE) begin
                if (!bit_end) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= last_data ? 3'd0 : bit_idx + 3'd1;
                    end else if (state == S_STOP) begin
                        bit_idx <= last_stop ? 3'd0 : bit_idx + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 @50MHz depth 16, 8E1 @1MHz depth 4, 7O2 @1MHz depth 4).
// Latency: expected frames come from a bit-level reference built from the frame format rules.
// Backpressure: overflow and full are exercised on the depth-4 instance.
module tb_uart_tx_fifo;

    logic clk_50mhz;
    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic [2:0]       rst_s, wr_en_s, full_s, empty_s, ovf_s, busy_s, txd, done_s;
    logic [2:0][2:0]  baud_s;
    logic [2:0][7:0]  wdat;
    logic [4:0]       lvl0;
    logic [2:0]       lvl1, lvl2;

    uart_tx_fifo u0 (
        .clk_50mhz(clk_50mhz), .rst(rst_s[0]), .baud(baud_s[0]), .wr_en(wr_en_s[0]),
        .wr_data(wdat[0]), .full(full_s[0]), .empty(empty_s[0]), .level(lvl0),
        .overflow(ovf_s[0]), .busy(busy_s[0]), .tx_data(txd[0]), .tx_done(done_s[0])
    );

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .PARITY(1), .FIFO_DEPTH(4)) u1 (
        .clk_50mhz(clk_50mhz), .rst(rst_s[1]), .baud(baud_s[1]), .wr_en(wr_en_s[1]),
        .wr_data(wdat[1]), .full(full_s[1]), .empty(empty_s[1]), .level(lvl1),
        .overflow(ovf_s[1]), .busy(busy_s[1]), .tx_data(txd[1]), .tx_done(done_s[1])
    );

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk_50mhz(clk_50mhz), .rst(rst_s[2]), .baud(baud_s[2]), .wr_en(wr_en_s[2]),
        .wr_data(wdat[2][6:0]), .full(full_s[2]), .empty(empty_s[2]), .level(lvl2),
        .overflow(ovf_s[2]), .busy(busy_s[2]), .tx_data(txd[2]), .tx_done(done_s[2])
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] mq[$];
    logic [7:0] d;

    // Instance configuration.
    function automatic int p_clk(int i); return (i == 0) ? 50_000_000 : 1_000_000; endfunction
    function automatic int p_db(int i);  return (i == 2) ? 7 : 8; endfunction
    function automatic int p_par(int i); return i; endfunction
    function automatic int p_sb(int i);  return (i == 2) ? 2 : 1; endfunction
    function automatic int nbits(int i);
        return 1 + p_db(i) + ((p_par(i) != 0) ? 1 : 0) + p_sb(i);
    endfunction

    function automatic int rate(logic [2:0] b);
        case (b)
            3'd0: return 9600;
            3'd1: return 19200;
            3'd2: return 38400;
            3'd3: return 57600;
            default: return 115200;
        endcase
    endfunction

    function automatic int divf(int i, logic [2:0] b);
        return p_clk(i) / rate(b);
    endfunction

    // Line level of bit n of the frame carrying word dd.
    function automatic logic exp_bit(int i, logic [7:0] dd, int n);
        int db;
        logic [7:0] m;
        db = p_db(i);
        m  = dd & 8'((1 << db) - 1);
        if (n == 0) return 1'b0;
        if (n <= db) return m[n-1];
        if (p_par(i) != 0 && n == db + 1)
            return (($countones(m) % 2) == 1) ^ (p_par(i) == 2);
        return 1'b1;
    endfunction

    function automatic logic [31:0] lvl(int i);
        case (i)
            0:       return 32'(lvl0);
            1:       return 32'(lvl1);
            default: return 32'(lvl2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    // Walk one frame from sample index k0 to its end, comparing every clock.
    task automatic frame_check(input int i, input logic [7:0] dd, input int dv, input int k0, input string tag);
        int total, bad, dbad, bbad;
        total = nbits(i) * dv;
        bad = 0; dbad = 0; bbad = 0;
        chk({tag, " level at start"}, lvl(i), mq.size());
        for (int k = k0; k < total; k++) begin
            if (txd[i] !== exp_bit(i, dd, k / dv)) bad++;
            if (done_s[i] !== (k == total - 1)) dbad++;
            if (k < total - 1 && busy_s[i] !== 1'b1) bbad++;
            tick();
        end
        chk({tag, " bit errors"}, bad, 0);
        chk({tag, " tx_done misplaced"}, dbad, 0);
        chk({tag, " busy dropped"}, bbad, 0);
    endtask

    task automatic idle_watch(input int i, input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            if (txd[i] !== 1'b1 || done_s[i] !== 1'b0 || busy_s[i] !== 1'b0) bad++;
            tick();
        end
        chk({tag, " activity while idle"}, bad, 0);
    endtask

    initial begin
        rst_s   = 3'b111;
        wr_en_s = '0;
        wdat    = '0;
        for (int i = 0; i < 3; i++) baud_s[i] = 3'd4;
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d tx_data", i), txd[i], 1);
            chk($sformatf("rst%0d busy", i), busy_s[i], 0);
            chk($sformatf("rst%0d tx_done", i), done_s[i], 0);
            chk($sformatf("rst%0d overflow", i), ovf_s[i], 0);
            chk($sformatf("rst%0d full", i), full_s[i], 0);
            chk($sformatf("rst%0d empty", i), empty_s[i], 1);
            chk($sformatf("rst%0d level", i), lvl(i), 0);
        end
        rst_s = '0;
        tick();

        // Single 0xA5 on 8N1 at 115200.
        wr_en_s[0] = 1'b1; wdat[0] = 8'hA5; mq.push_back(8'hA5);
        tick();
        wr_en_s[0] = 1'b0;
        chk("a5 empty after write", empty_s[0], 0);
        chk("a5 level after write", lvl(0), 1);
        chk("a5 line high 1 clk after", txd[0], 1);
        tick();
        d = mq.pop_front();
        chk("a5 busy after pop", busy_s[0], 1);
        chk("a5 line high before fall", txd[0], 1);
        tick();
        chk("a5 latency fall", txd[0], 0);
        frame_check(0, d, divf(0, 3'd4), 0, "a5");
        chk("a5 busy after frame", busy_s[0], 0);
        chk("a5 empty after frame", empty_s[0], 1);
        idle_watch(0, 20, "a5");

        // Filler frame, then three queued words sent back-to-back.
        d = 8'($urandom_range(255));
        wr_en_s[0] = 1'b1; wdat[0] = d; mq.push_back(d);
        tick();
        wr_en_s[0] = 1'b0;
        tick();
        d = mq.pop_front();
        tick();
        wr_en_s[0] = 1'b1;
        wdat[0] = 8'h11; mq.push_back(8'h11); tick();
        wdat[0] = 8'h22; mq.push_back(8'h22); tick();
        wdat[0] = 8'h33; mq.push_back(8'h33); tick();
        wr_en_s[0] = 1'b0;
        frame_check(0, d, divf(0, 3'd4), 3, "b2b filler");
        for (int j = 0; j < 3; j++) begin
            d = mq.pop_front();
            frame_check(0, d, divf(0, 3'd4), 0, $sformatf("b2b word%0d", j));
        end
        chk("b2b empty at end", empty_s[0], 1);

        // Even parity with 0x07, baud switched to 9600 mid-frame.
        wr_en_s[1] = 1'b1; wdat[1] = 8'h07; mq.push_back(8'h07);
        tick();
        d = 8'($urandom_range(255));
        wdat[1] = d; mq.push_back(d);
        tick();
        d = mq.pop_front();
        wr_en_s[1] = 1'b0;
        baud_s[1] = 3'd0;
        tick();
        chk("even parity bit of 0x07", exp_bit(1, 8'h07, 9), 1);
        frame_check(1, d, divf(1, 3'd4), 0, "even 0x07 old baud");
        d = mq.pop_front();
        frame_check(1, d, divf(1, 3'd0), 0, "even new baud");
        baud_s[1] = 3'd4;
        tick();

        // Depth-4 overflow: five writes while a frame is in flight.
        d = 8'($urandom_range(255));
        wr_en_s[1] = 1'b1; wdat[1] = d; mq.push_back(d);
        tick();
        wr_en_s[1] = 1'b0;
        tick();
        d = mq.pop_front();
        tick();
        wr_en_s[1] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wdat[1] = 8'($urandom_range(255));
            if (n < 4) mq.push_back(wdat[1]);
            tick();
            chk($sformatf("ovf level w%0d", n), lvl(1), (n < 4) ? n + 1 : 4);
            chk($sformatf("ovf full w%0d", n), full_s[1], (n >= 3) ? 1 : 0);
            chk($sformatf("ovf pulse w%0d", n), ovf_s[1], (n == 4) ? 1 : 0);
        end
        wr_en_s[1] = 1'b0;
        tick();
        chk("ovf pulse cleared", ovf_s[1], 0);
        chk("ovf level held", lvl(1), 4);
        frame_check(1, d, divf(1, 3'd4), 6, "ovf first");
        for (int j = 0; j < 4; j++) begin
            d = mq.pop_front();
            frame_check(1, d, divf(1, 3'd4), 0, $sformatf("ovf queued%0d", j));
        end
        idle_watch(1, 200, "ovf dropped word");

        // 7O2 bursts at random rates; first word 0x07 gives odd parity 0.
        for (int b = 0; b < 3; b++) begin
            baud_s[2] = (b == 0) ? 3'd4 : 3'($urandom_range(7));
            wr_en_s[2] = 1'b1;
            for (int w = 0; w < 3; w++) begin
                wdat[2] = (b == 0 && w == 0) ? 8'h07 : 8'($urandom_range(255));
                mq.push_back(wdat[2]);
                tick();
                if (w == 1) d = mq.pop_front();
            end
            wr_en_s[2] = 1'b0;
            if (b == 0) chk("odd parity bit of 0x07", exp_bit(2, 8'h07, 8), 0);
            frame_check(2, d, divf(2, baud_s[2]), 0, $sformatf("7o2 b%0d w0", b));
            for (int w = 1; w < 3; w++) begin
                d = mq.pop_front();
                frame_check(2, d, divf(2, baud_s[2]), 0, $sformatf("7o2 b%0d w%0d", b, w));
            end
            idle_watch(2, 10, $sformatf("7o2 b%0d", b));
        end

        // Reset in the middle of the data bits with two words still queued.
        wr_en_s[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wdat[0] = 8'($urandom_range(255));
            tick();
        end
        wr_en_s[0] = 1'b0;
        chk("rst-mid level queued", lvl(0), 2);
        for (int k = 0; k < divf(0, 3'd4) * 4; k++) tick();
        chk("rst-mid busy before", busy_s[0], 1);
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        mq.delete();
        chk("rst-mid tx_data", txd[0], 1);
        chk("rst-mid busy", busy_s[0], 0);
        chk("rst-mid empty", empty_s[0], 1);
        chk("rst-mid level", lvl(0), 0);
        chk("rst-mid tx_done", done_s[0], 0);
        idle_watch(0, 3000, "rst-mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter.
- Buffers outgoing words in an internal FIFO and serialises them with configurable data width, parity mode and stop-bit count.
- Sends frames back-to-back while words remain queued.
- Keeps the 3-bit baud-select input used by the existing transmitter, so a key-triggered top level can push several bytes per press instead of one.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz; used to derive the bit divisors.
- DATA_BITS, 8: data bits per frame; legal values 5..8.
- PARITY, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, minimum 2.

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous, active-high reset
- baud  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4..7=115200
- wr_en  in  1  push wr_data into the FIFO this cycle
- wr_data  in  DATA_BITS  word to send
- full  out  1  FIFO holds FIFO_DEPTH words
- empty  out  1  FIFO holds no words
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  one-cycle pulse when wr_en is rejected because the FIFO is full
- busy  out  1  a frame is in progress (any state other than IDLE)
- tx_data  out  1  serial line; idles high
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
Interface rules
- Single clock domain. Reset is synchronous and active-high: rst is sampled only on the rising edge of clk_50mhz, and rst=1 resets the block.

Reset values
- tx_data=1, busy=0, tx_done=0, overflow=0, full=0, empty=1, level=0.
- FIFO pointers are cleared; state = IDLE.
- Reset mid-frame aborts the frame immediately (tx_data returns high on the next cycle) and discards all queued words.

Bit timing
- Bit period DIV = CLK_FREQ/rate, integer truncation. At 50 MHz: 5208, 2604, 1302, 868, 434 clocks.
- The 3-bit baud value is latched at the start of each frame; changing baud mid-frame has no effect until the next frame.
- Each bit is held for exactly DIV clocks.

FIFO
- Write is accepted when wr_en=1 and full=0.
- When full=1, the write is dropped and overflow pulses for one cycle. This holds even if a pop occurs in the same cycle.
- A simultaneous accepted write and pop leaves level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- full, empty and level are registered and reflect the state after the clock edge.

Frame format
- Start bit (0), then DATA_BITS data bits LSB first.
- Then a parity bit if PARITY != 0: even parity makes the total count of ones in data+parity even; odd parity makes it odd.
- Then STOP_BITS stop bits (1).
- Frame length = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.

State machine: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE or START.
- IDLE: if empty=0, pop the FIFO head into the shift register, latch baud, go to START.
- START: drive 0 for DIV clocks.
- DATA: shift out DATA_BITS bits.
- PARITY: drive the computed parity bit for DIV clocks.
- STOP: drive 1 for STOP_BITS*DIV clocks.
- End of STOP: pulse tx_done. If the FIFO is non-empty, pop in the same cycle and enter START directly, with zero idle cycles between frames; otherwise enter IDLE.

Latency
- A write into an empty FIFO with the transmitter in IDLE causes tx_data to fall exactly 2 clocks after the clock edge that sampled wr_en.

Test Plan:
- 8N1, baud=4, single write of 0xA5 -> tx_data low 2 clocks after the write. Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 434 clocks. tx_done pulses once at cycle 4340 of the frame; busy falls afterwards; empty=1.
- PARITY=1 (even), then PARITY=2 (odd), data 0x07 -> parity bit 1 for even, 0 for odd. Frame is 11 bits.
- Three consecutive writes 0x11, 0x22, 0x33 -> three frames with no idle clocks between a stop bit and the next start bit. Three tx_done pulses spaced 4340 clocks apart; level steps 3→2→1→0 at each pop.
- FIFO_DEPTH=4, five writes in consecutive cycles while the transmitter is busy -> full asserts after the 4th accepted write; the 5th write raises overflow for exactly one cycle; level=4; the 5th word is never transmitted.
- baud changed from 4 to 0 mid-frame -> current frame keeps 434-clock bits; next frame uses 5208-clock bits.
- rst asserted midway through the data bits with 2 words queued -> next cycle tx_data=1, busy=0, empty=1, level=0; no tx_done pulse; no further frames transmitted.
